// File: rtl/program_loader.sv
// program_loader: streams words from an upstream valid/ready source into a RAM
// while holding the processor in reset. It then reads the words back and
// compares the read checksum with the write checksum.
module program_loader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_count,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_mem_we,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_cpu_hold,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] VERIFY = 3'd2;
    localparam logic [2:0] CHECK  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    // Count saturates at the RAM depth, which needs one extra bit.
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [2:0]            state;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   index;   // next write address
    logic [ADDR_WIDTH:0]   raddr;   // next readback address to issue
    logic [ADDR_WIDTH:0]   rcnt;    // readback words already summed
    logic [DATA_WIDTH-1:0] wsum;
    logic [DATA_WIDTH-1:0] rsum;
    logic                  issue;   // a read address is on o_mem_addr this cycle
    logic                  rvalid;  // i_mem_rdata holds a requested word this cycle
    logic                  hs;

    // Upstream handshake.
    always_comb begin
        hs = i_valid & o_ready;
    end

    // Sequencer: all outputs, counters and checksums are registered here.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            count       <= '0;
            index       <= '0;
            raddr       <= '0;
            rcnt        <= '0;
            wsum        <= '0;
            rsum        <= '0;
            issue       <= 1'b0;
            rvalid      <= 1'b0;
            o_ready     <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_we    <= 1'b0;
            o_cpu_hold  <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            o_mem_we <= 1'b0;
            o_done   <= 1'b0;
            issue    <= 1'b0;
            rvalid   <= issue;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_error <= 1'b0;
                        o_busy  <= 1'b1;
                        index   <= '0;
                        raddr   <= '0;
                        rcnt    <= '0;
                        wsum    <= '0;
                        rsum    <= '0;
                        if (i_count == '0) begin
                            state <= DONE;
                        end else begin
                            count      <= (i_count > DEPTH) ? DEPTH : i_count;
                            o_ready    <= 1'b1;
                            o_cpu_hold <= 1'b1;
                            state      <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (hs) begin
                        o_mem_we    <= 1'b1;
                        o_mem_addr  <= index[ADDR_WIDTH-1:0];
                        o_mem_wdata <= i_data;
                        wsum        <= wsum + i_data;
                        index       <= index + 1'b1;
                        if (index == count - 1'b1) begin
                            o_ready <= 1'b0;
                            state   <= VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    // The final write is still on the bus during the first VERIFY
                    // cycle; the first read address replaces it one edge later.
                    if (raddr != count) begin
                        o_mem_addr <= raddr[ADDR_WIDTH-1:0];
                        issue      <= 1'b1;
                        raddr      <= raddr + 1'b1;
                    end
                    if (rvalid) begin
                        rsum <= rsum + i_mem_rdata;
                        rcnt <= rcnt + 1'b1;
                        if (rcnt == count - 1'b1) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    o_error <= (rsum != wsum);
                    state   <= DONE;
                end
                DONE: begin
                    o_done     <= 1'b1;
                    o_cpu_hold <= 1'b0;
                    o_busy     <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed loads of program_loader into a behavioural RAM.
// Stimulus pushes expected writes and completions into queues; a monitor pops
// and compares them whenever the DUT writes or pulses o_done.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [8:0]  i_count;
    logic        i_valid;
    logic [15:0] i_data;
    logic        o_ready;
    logic [7:0]  o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic        o_mem_we;
    logic [15:0] i_mem_rdata;
    logic        o_cpu_hold;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic err;
        int   cyc;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int wr_seen = 0;
    int last_hs = 0;

    logic [15:0] mem [0:255];
    logic        corrupt = 1'b0;
    logic [7:0]  corrupt_addr = 8'd0;
    logic        mem_clr = 1'b0;
    logic [15:0] words [0:7];

    program_loader #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(8)
    ) dut (
        .i_clock    (clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_count    (i_count),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .o_mem_addr (o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .o_mem_we   (o_mem_we),
        .i_mem_rdata(i_mem_rdata),
        .o_cpu_hold (o_cpu_hold),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_error    (o_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM model with a bench-side corruption/clear port.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 256; k++) mem[k] <= '0;
        end else if (o_mem_we) begin
            mem[o_mem_addr] <= o_mem_wdata;
        end else if (corrupt) begin
            mem[corrupt_addr] <= '0;
        end
        i_mem_rdata <= mem[o_mem_addr];
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops expectations when the DUT writes or completes.
    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        if (!i_reset) begin
            if (o_mem_we) begin
                wr_seen++;
                if (wq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                             o_mem_addr, o_mem_wdata);
                end else begin
                    w = wq.pop_front();
                    chk("write_addr", {24'd0, o_mem_addr}, {24'd0, w.addr});
                    chk("write_data", {16'd0, o_mem_wdata}, {16'd0, w.data});
                    chk("hold_during_write", {31'd0, o_cpu_hold}, 32'd1);
                end
            end
            if (o_done) begin
                if (dq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done: got o_done=1 expected 0");
                end else begin
                    d = dq.pop_front();
                    chk("done_error", {31'd0, o_error}, {31'd0, d.err});
                    chk("done_latency", cyc, d.cyc);
                    chk("done_hold_low", {31'd0, o_cpu_hold}, 32'd0);
                    chk("done_writes_drained", wq.size(), 32'd0);
                end
            end
        end
    end

    task automatic start_load(input int cnt);
        i_start = 1'b1;
        i_count = cnt[8:0];
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] w);
        int t;
        t = 0;
        i_valid = 1'b1;
        i_data  = w;
        while (!o_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!o_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready_timeout: got o_ready=0 expected 1 within 50 cycles");
        end
        @(negedge clk);
        last_hs = cyc;
        i_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (dq.size() != 0 && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (dq.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL done_timeout: got no o_done expected one within 600 cycles");
            dq.delete();
            wq.delete();
        end
        @(negedge clk);
        chk("idle_busy_low", {31'd0, o_busy}, 32'd0);
    endtask

    // One complete load; data from words[] or a counting pattern.
    task automatic do_load(input int cnt, input int nwords, input bit gaps,
                           input bit use_pat, input bit exp_err, input bit corrupt3);
        int   n0;
        wr_t  w;
        dn_t  d;
        n0 = wr_seen;
        start_load(cnt);
        chk("busy_after_start", {31'd0, o_busy}, 32'd1);
        chk("error_cleared_on_start", {31'd0, o_error}, 32'd0);
        for (int i = 0; i < nwords; i++) begin
            w.addr = i[7:0];
            w.data = use_pat ? words[i] : 16'(i * 3 + 1);
            wq.push_back(w);
            push_word(w.data);
            if (gaps && i != nwords - 1) @(negedge clk);
        end
        chk("ready_low_after_last", {31'd0, o_ready}, 32'd0);
        d.err = exp_err;
        d.cyc = last_hs + nwords + 4;
        dq.push_back(d);
        if (corrupt3) begin
            @(negedge clk);
            corrupt_addr = 8'd3;
            corrupt = 1'b1;
            @(negedge clk);
            corrupt = 1'b0;
        end
        wait_done();
        chk("write_pulse_count", wr_seen - n0, nwords);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ready",  {31'd0, o_ready}, 32'd0);
        chk("rst_we",     {31'd0, o_mem_we}, 32'd0);
        chk("rst_addr",   {24'd0, o_mem_addr}, 32'd0);
        chk("rst_wdata",  {16'd0, o_mem_wdata}, 32'd0);
        chk("rst_hold",   {31'd0, o_cpu_hold}, 32'd0);
        chk("rst_busy",   {31'd0, o_busy}, 32'd0);
        chk("rst_done",   {31'd0, o_done}, 32'd0);
        chk("rst_error",  {31'd0, o_error}, 32'd0);
    endtask

    task automatic clear_ram();
        mem_clr = 1'b1;
        @(negedge clk);
        mem_clr = 1'b0;
    endtask

    initial begin
        dn_t d;
        i_reset = 1'b1;
        i_start = 1'b0;
        i_count = '0;
        i_valid = 1'b0;
        i_data  = '0;
        words[0] = 16'hE210; words[1] = 16'h2210; words[2] = 16'h4210; words[3] = 16'h6210;
        words[4] = 16'h8210; words[5] = 16'hA210; words[6] = 16'hC210; words[7] = 16'h0610;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        i_reset = 1'b0;
        clear_ram();

        // Back-to-back load of 8 words.
        do_load(8, 8, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) chk("ram_b2b", {16'd0, mem[i]}, {16'd0, words[i]});

        // Same words with i_valid low every other cycle.
        clear_ram();
        do_load(8, 8, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) chk("ram_gaps", {16'd0, mem[i]}, {16'd0, words[i]});

        // RAM[3] cleared between its write and its readback.
        do_load(8, 8, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("error_held", {31'd0, o_error}, 32'd1);

        // Zero-length load: completion without RAM access, error cleared.
        d.err = 1'b0;
        d.cyc = cyc + 2;
        dq.push_back(d);
        start_load(0);
        wait_done();

        // Reset after 4 of 8 words, then a fresh 2-word load.
        start_load(8);
        for (int i = 0; i < 4; i++) begin
            wr_t w;
            w.addr = i[7:0];
            w.data = words[i];
            wq.push_back(w);
            push_word(words[i]);
        end
        #1 i_reset = 1'b1;
        #1 check_reset_outputs();
        chk("rst_writes_drained", wq.size(), 32'd0);
        wq.delete();
        @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        words[0] = 16'h0030;
        words[1] = 16'h0014;
        do_load(2, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ram_after_reset0", {16'd0, mem[0]}, 32'h0030);
        chk("ram_after_reset1", {16'd0, mem[1]}, 32'h0014);

        // Oversized count saturates to the full 256-word depth.
        do_load(256 + 5, 256, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_last_word", {16'd0, mem[255]}, 32'(255 * 3 + 1));
        chk("sat_first_word", {16'd0, mem[0]}, 32'd1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of instruction/data words.
REQ-002 Parameter ADDR_WIDTH, default 8, memory word address width; depth = 2**ADDR_WIDTH.
REQ-003 i_clock  input  1  single clock; all state changes on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 i_count  input  ADDR_WIDTH+1  number of words to load; sampled with i_start.
REQ-007 i_valid  input  1  upstream word valid.
REQ-008 i_data  input  DATA_WIDTH  upstream word.
REQ-009 o_ready  output  1  loader accepts i_data this cycle.
REQ-010 o_mem_addr  output  ADDR_WIDTH  RAM port address, write and readback.
REQ-011 o_mem_wdata  output  DATA_WIDTH  RAM write data.
REQ-012 o_mem_we  output  1  RAM write enable.
REQ-013 i_mem_rdata  input  DATA_WIDTH  RAM read data, valid one cycle after address.
REQ-014 o_cpu_hold  output  1  holds processor in reset while a load is in progress.
REQ-015 o_busy  output  1  high in any state other than IDLE.
REQ-016 o_done  output  1  one-cycle completion pulse.
REQ-017 o_error  output  1  readback checksum mismatch of the last load.

Function
REQ-018 States IDLE, LOAD, VERIFY, CHECK, DONE; all outputs registered.
REQ-019 IDLE: i_start=1 and i_count!=0 -> LOAD; clear word index, write checksum, read checksum, o_error; set o_cpu_hold=1.
REQ-020 IDLE: i_start=1 and i_count=0 -> DONE with no RAM access; o_error cleared.
REQ-021 i_count above depth saturates to depth; count register ADDR_WIDTH+1 bits.
REQ-022 i_start outside IDLE ignored.
REQ-023 LOAD: o_ready=1; handshake = i_valid & o_ready; no handshake = no state change.
REQ-024 Each handshake: next cycle o_mem_we=1, o_mem_addr=index, o_mem_wdata=accepted word; index increments; one word per cycle back-to-back.
REQ-025 Write checksum = sum of accepted words modulo 2**DATA_WIDTH.
REQ-026 Handshake of word count-1 -> VERIFY; o_ready low from the next cycle; final write still issued.
REQ-027 o_mem_we low in every cycle without a pending write.
REQ-028 VERIFY: read addresses 0..count-1 issued one per cycle, o_mem_we=0; i_mem_rdata summed modulo 2**DATA_WIDTH one cycle after each address.
REQ-029 After last read data summed -> CHECK; o_error = (read checksum != write checksum).
REQ-030 CHECK -> DONE next cycle; DONE: o_done=1 for one cycle, o_cpu_hold=0, -> IDLE.
REQ-031 o_error held until next accepted i_start or reset.
REQ-032 Load of full depth: last address 2**ADDR_WIDTH-1, index does not wrap into address 0 before VERIFY.
REQ-033 Total latency: last handshake to o_done = count + 4 cycles.

Reset
REQ-034 i_reset=1 at any time, including mid-load: state IDLE, o_ready=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_cpu_hold=0, o_busy=0, o_done=0, o_error=0, counters and checksums 0.
REQ-035 Partially written RAM contents after reset are not restored; a new i_start is required.

Verification
REQ-036 count=8, words E210,2210,4210,6210,8210,A210,C210,0610 back-to-back -> RAM[0..7] equal those words, 8 write pulses, o_done after 12 cycles, o_error=0, o_cpu_hold low after o_done.
REQ-037 Same 8 words with i_valid low every other cycle -> identical RAM contents, no write during gaps, o_error=0.
REQ-038 i_start with i_count=0 -> o_done within 2 cycles, o_mem_we never high, o_error=0.
REQ-039 Bench forces RAM[3]=0000 between last write and its readback -> o_error=1 with o_done; o_error stays 1 until next i_start.
REQ-040 i_reset asserted after 4 of 8 words -> all outputs reset values same cycle; new load of 2 words 0030,0014 completes with o_error=0.
REQ-041 i_count=2**ADDR_WIDTH+5 -> exactly 2**ADDR_WIDTH words accepted, last write address 2**ADDR_WIDTH-1, o_ready low afterwards.
